word_aligner16: RTL

Receive-side word aligner that pairs with the 16-bit rotator datapath. The transmit end rotates the stream left by an unknown fixed amount k and periodically inserts SYNC_WORD. This block hunts for SYNC_WORD at any of the 16 rotations and confirms it over several occurrences. Once locked, it right-rotates every following word by k to restore the original alignment, and drops lock after repeated missing sync words.

---
 rtl/word_align_pkg.sv | 24 ++
 rtl/sync_match16.sv | 36 +++
 rtl/word_aligner16.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/word_align_pkg.sv
// ============================================================================
// word_align_pkg : shared state encoding, default sync pattern, rotate helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package word_align_pkg;

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] CONFIRM = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA5C3;

    // Duplicating the word lets a plain right shift act as a 16-bit rotate.
    function automatic logic [15:0] rotr16(input logic [15:0] x, input logic [3:0] r);
        logic [31:0] w_dbl;
        w_dbl = {x, x} >> r;
        return w_dbl[15:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_match16.sv
// ============================================================================
// sync_match16 : compares all 16 right-rotations of a word against the sync
//                pattern and reports the lowest matching rotation
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_match16
    import word_align_pkg::*;
(
    input  logic [15:0] in_data,
    input  logic [15:0] sync_word,
    output logic        hit,
    output logic [3:0]  hit_idx
);

    logic [15:0] w_hit_vec;

    for (genvar r = 0; r < 16; r++) begin : g_cmp
        assign w_hit_vec[r] = (rotr16(in_data, 4'(r)) == sync_word);
    end

    // Scanning downward leaves the lowest set index as the final winner.
    always_comb begin
        hit     = |w_hit_vec;
        hit_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                hit_idx = 4'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/word_aligner16.sv
// ============================================================================
// word_aligner16 : hunts for a rotated sync word, confirms it, then
//                  de-rotates the stream until repeated sync slots are missed
// Revision: 1.0
// ============================================================================
`default_nettype none

module word_aligner16
    import word_align_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
    parameter int unsigned LOCK_COUNT    = 3,
    parameter int unsigned MAX_GAP       = 64,
    parameter int unsigned UNLOCK_MISSES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_is_sync,
    output logic        locked,
    output logic [3:0]  rot_amt
);

    localparam logic [3:0] C_LOCK_COUNT    = 4'(LOCK_COUNT);
    localparam logic [7:0] C_MAX_GAP       = 8'(MAX_GAP);
    localparam logic [3:0] C_UNLOCK_MISSES = 4'(UNLOCK_MISSES);

    logic [1:0]  r_state;
    logic [3:0]  r_hit_cnt;
    logic [7:0]  r_gap_cnt;
    logic [3:0]  r_miss_cnt;

    logic        w_hit;
    logic [3:0]  w_hit_idx;
    logic        w_hit_here;
    logic [7:0]  w_gap_inc;
    logic [1:0]  w_state;
    logic [3:0]  w_rot;
    logic [3:0]  w_hit_cnt;
    logic [7:0]  w_gap_cnt;
    logic [3:0]  w_miss_cnt;
    logic        w_miss_evt;
    logic        w_accept;
    logic [15:0] w_rot_data;

    sync_match16 u_match (
        .in_data   (in_data),
        .sync_word (SYNC_WORD),
        .hit       (w_hit),
        .hit_idx   (w_hit_idx)
    );

    assign w_hit_here = w_hit && (w_hit_idx == rot_amt);
    assign w_gap_inc  = (r_gap_cnt == 8'hFF) ? r_gap_cnt : r_gap_cnt + 8'd1;

    always_comb begin
        w_state    = r_state;
        w_rot      = rot_amt;
        w_hit_cnt  = r_hit_cnt;
        w_gap_cnt  = r_gap_cnt;
        w_miss_cnt = r_miss_cnt;
        w_miss_evt = 1'b0;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    w_gap_cnt = w_gap_inc;
                    if (w_hit) begin
                        w_rot      = w_hit_idx;
                        w_hit_cnt  = 4'd1;
                        w_gap_cnt  = 8'd0;
                        w_miss_cnt = 4'd0;
                        w_state    = (LOCK_COUNT == 1) ? LOCKED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (w_hit_here) begin
                        w_hit_cnt = r_hit_cnt + 4'd1;
                        w_gap_cnt = 8'd0;
                        if (r_hit_cnt + 4'd1 == C_LOCK_COUNT) begin
                            w_state    = LOCKED;
                            w_miss_cnt = 4'd0;
                        end
                    end else if (w_hit) begin
                        w_rot     = w_hit_idx;
                        w_hit_cnt = 4'd1;
                        w_gap_cnt = 8'd0;
                    end else begin
                        w_gap_cnt = w_gap_inc;
                        if (w_gap_inc == C_MAX_GAP) begin
                            w_state   = HUNT;
                            w_hit_cnt = 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (w_hit_here) begin
                        w_gap_cnt  = 8'd0;
                        w_miss_cnt = 4'd0;
                    end else if (w_hit) begin
                        w_gap_cnt  = 8'd0;
                        w_miss_evt = 1'b1;
                    end else if (w_gap_inc == C_MAX_GAP) begin
                        w_gap_cnt  = 8'd0;
                        w_miss_evt = 1'b1;
                    end else begin
                        w_gap_cnt  = w_gap_inc;
                    end
                end
                default: begin
                    w_state = HUNT;
                end
            endcase
            // Miss counter clears on unlock so a later relock starts fresh.
            if (w_miss_evt) begin
                if (r_miss_cnt + 4'd1 == C_UNLOCK_MISSES) begin
                    w_state    = HUNT;
                    w_miss_cnt = 4'd0;
                end else begin
                    w_miss_cnt = r_miss_cnt + 4'd1;
                end
            end
        end
    end

    assign w_accept   = in_valid && (w_state == LOCKED);
    assign w_rot_data = rotr16(in_data, w_rot);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_hit_cnt   <= 4'd0;
            r_gap_cnt   <= 8'd0;
            r_miss_cnt  <= 4'd0;
            rot_amt     <= 4'd0;
            locked      <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 16'h0000;
            out_is_sync <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_hit_cnt  <= w_hit_cnt;
            r_gap_cnt  <= w_gap_cnt;
            r_miss_cnt <= w_miss_cnt;
            rot_amt    <= w_rot;
            locked     <= (w_state == LOCKED);
            out_valid  <= w_accept;
            if (w_accept) begin
                out_data    <= w_rot_data;
                out_is_sync <= (w_rot_data == SYNC_WORD);
            end
        end
    end

endmodule

`default_nettype wire
